// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - pipeline request/response and word-memory bus of the load/store unit
//
// Purpose: groups the request handshake, the completion response and the
// word-memory strobes into one bundle.
// Modports:
//   slave  - load/store unit view: takes requests and memory read data,
//            drives req_ready, the response and the memory strobes.
//   master - pipeline/memory view: the mirror image of slave.
// Signals:
//   req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata - request
//   resp_valid/resp_rdata/resp_fault                         - completion
//   mem_valid/mem_we/mem_addr/mem_wdata/mem_rdata            - word memory

interface load_store_unit_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            resp_valid;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_fault;
    logic            mem_valid;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_fault,
        output mem_valid, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
        input  mem_valid, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit in front of a word-wide memory
//
// Purpose: accepts one load or store at a time, performs it on a word memory
// (read-modify-write for byte/half stores) and reports completion with a
// one-cycle resp_valid pulse. Illegal funct3 codes fault without touching memory.
// Optional feature: define LSU_MISALIGN_TRAP_EN to fault misaligned half/word
// accesses; otherwise the low address bits below the access size are ignored.
// Ports:
//   clk - clock, rising edge
//   rst - synchronous active-low reset
//   bus - load_store_unit_if.slave (request, response and memory signals)

module load_store_unit #(
    parameter int XLEN = 32
) (
    input logic               clk,
    input logic               rst,
    load_store_unit_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, LOAD, RMW_READ, WRITE, FAULT} state_t;

    state_t          state_q, state_d;
    logic            we_q, we_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] merge_q, merge_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            resp_valid_q, resp_valid_d;
    logic            resp_fault_q, resp_fault_d;

    logic            req_illegal;
    logic            req_misaligned;
    logic [7:0]      byte_lane;
    logic [15:0]     half_lane;
    logic [XLEN-1:0] load_ext;
    logic [XLEN-1:0] store_word;
    logic            mem_valid_c, mem_we_c;
    logic [XLEN-1:0] mem_wdata_c;

    // Fault decode on the incoming request, evaluated at acceptance.
    always_comb begin
        if (bus.req_we) begin
            req_illegal = (bus.req_funct3 > 3'b010);
        end else begin
            req_illegal = (bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110) ||
                          (bus.req_funct3 == 3'b111);
        end
`ifdef LSU_MISALIGN_TRAP_EN
        req_misaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                         ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
        req_misaligned = 1'b0;
`endif
    end

    // Lane selection: half lanes use only addr[1], so addr[0] is ignored for halves.
    assign byte_lane = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    assign half_lane = bus.mem_rdata[{addr_q[1], 4'b0000} +: 16];

    // funct3[2] marks the unsigned variants (LBU/LHU).
    always_comb begin
        case (funct3_q[1:0])
            2'b00:   load_ext = {{(XLEN-8){~funct3_q[2] & byte_lane[7]}}, byte_lane};
            2'b01:   load_ext = {{(XLEN-16){~funct3_q[2] & half_lane[15]}}, half_lane};
            default: load_ext = bus.mem_rdata;
        endcase
    end

    // Store data: the merge register with the addressed lane overwritten, or the full word for SW.
    always_comb begin
        store_word = merge_q;
        case (funct3_q[1:0])
            2'b00:   store_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            2'b01:   store_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: store_word = wdata_q;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        funct3_d     = funct3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        merge_d      = merge_q;
        rdata_d      = rdata_q;
        resp_valid_d = 1'b0;
        resp_fault_d = 1'b0;
        mem_valid_c  = 1'b0;
        mem_we_c     = 1'b0;
        mem_wdata_c  = '0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d     = bus.req_we;
                    funct3_d = bus.req_funct3;
                    addr_d   = bus.req_addr;
                    wdata_d  = bus.req_wdata;
                    if (req_illegal || req_misaligned) begin
                        state_d = FAULT;
                    end else if (!bus.req_we) begin
                        state_d = LOAD;
                    end else if (bus.req_funct3[1:0] == 2'b10) begin
                        state_d = WRITE;
                    end else begin
                        state_d = RMW_READ;
                    end
                end
            end
            LOAD: begin
                mem_valid_c  = 1'b1;
                rdata_d      = we_q ? '0 : load_ext;
                resp_valid_d = 1'b1;
                state_d      = IDLE;
            end
            RMW_READ: begin
                mem_valid_c = 1'b1;
                merge_d     = bus.mem_rdata;
                state_d     = WRITE;
            end
            WRITE: begin
                mem_valid_c  = 1'b1;
                mem_we_c     = 1'b1;
                mem_wdata_c  = store_word;
                rdata_d      = '0;
                resp_valid_d = 1'b1;
                state_d      = IDLE;
            end
            FAULT: begin
                rdata_d      = '0;
                resp_valid_d = 1'b1;
                resp_fault_d = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            funct3_q     <= 3'b000;
            addr_q       <= '0;
            wdata_q      <= '0;
            merge_q      <= '0;
            rdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            funct3_q     <= funct3_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            merge_q      <= merge_d;
            rdata_q      <= rdata_d;
            resp_valid_q <= resp_valid_d;
            resp_fault_q <= resp_fault_d;
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_fault = resp_fault_q;
    // Strobes are gated by reset combinationally so a reset in WRITE never reaches memory.
    assign bus.mem_valid  = rst & mem_valid_c;
    assign bus.mem_we     = rst & mem_we_c;
    assign bus.mem_addr   = {addr_q[XLEN-1:2], 2'b00};
    assign bus.mem_wdata  = mem_wdata_c;
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit

module tb_load_store_unit;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        fault;
        logic [31:0] rdata;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    load_store_unit_if #(.XLEN(32)) bus ();
    load_store_unit #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [31:0] mem       [0:63];
    logic [31:0] model_mem [0:63];
    int          wr_cnt;
    logic [31:0] wr_addr, wr_data;
    logic        mv_seen;
    int          n_checks = 0;
    int          n_err = 0;

    assign bus.mem_rdata = mem[bus.mem_addr[7:2]];

    always @(posedge clk) begin
        if (bus.mem_valid) mv_seen = 1'b1;
        if (bus.mem_valid && bus.mem_we) begin
            mem[bus.mem_addr[7:2]] = bus.mem_wdata;
            wr_cnt  = wr_cnt + 1;
            wr_addr = bus.mem_addr;
            wr_data = bus.mem_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: byte-addressed semantics computed with plain arithmetic on a word array.
    task automatic model_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, output logic f,
                                output logic [31:0] rd, output int lat);
        int          size;
        int          off;
        logic [31:0] mask, word, val;
        logic        illegal, mis;
        size    = 1 << f3[1:0];
        illegal = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        mis     = (addr % size) != 0;
        f       = illegal || (TRAP && mis);
        off     = (addr % 4) - (addr % size);
        mask    = (size >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
        word    = model_mem[(addr / 4) % 64];
        rd      = 32'h0;
        if (f) begin
            lat = 2;
        end else if (!we) begin
            val = (word >> (8 * off)) & mask;
            if (!f3[2] && size < 4 && val[8 * size - 1]) val = val | ~mask;
            rd  = val;
            lat = 2;
        end else begin
            model_mem[(addr / 4) % 64] = (word & ~(mask << (8 * off))) | ((wdata & mask) << (8 * off));
            lat = (size == 4) ? 2 : 3;
        end
    endtask

    // Called just after a negedge; returns at the negedge where resp_valid is seen (or budget out).
    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic got,
                           output logic [31:0] rd, output logic f, output int lat);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        chk("req_ready at issue", {31'b0, bus.req_ready}, 32'd1);
        @(posedge clk);
        got = 1'b0; rd = 32'h0; f = 1'b0; lat = 0;
        while (!got && lat < 8) begin
            @(negedge clk);
            lat++;
            if (lat == 1) bus.req_valid = 1'b0;
            if (bus.resp_valid) begin
                got = 1'b1;
                rd  = bus.resp_rdata;
                f   = bus.resp_fault;
            end
        end
    endtask

    logic        e_f, a_f, a_got;
    logic [31:0] e_rd, a_rd;
    int          e_lat, a_lat;

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
        model_access(we, f3, addr, wdata, e_f, e_rd, e_lat);
        run_req(we, f3, addr, wdata, a_got, a_rd, a_f, a_lat);
    endtask

    vec_t vecs[$];

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr, wdata;
        int          w0, bad, seen;

        for (int i = 0; i < 64; i++) begin
            mem[i] = 32'h0;
            model_mem[i] = 32'h0;
        end
        mem[4]  = 32'h8899AABB; model_mem[4]  = 32'h8899AABB;
        mem[8]  = 32'h11223344; model_mem[8]  = 32'h11223344;
        mem[16] = 32'hCAFEF00D; model_mem[16] = 32'hCAFEF00D;
        mem[20] = 32'h01020304; model_mem[20] = 32'h01020304;
        wr_cnt = 0; wr_addr = 32'h0; wr_data = 32'h0; mv_seen = 1'b0;
        rst = 1'b0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0;

        repeat (3) @(negedge clk);
        chk("reset req_ready",  {31'b0, bus.req_ready},  32'd1);
        chk("reset resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        chk("reset resp_fault", {31'b0, bus.resp_fault}, 32'd0);
        chk("reset resp_rdata", bus.resp_rdata, 32'h0);
        chk("reset mem_valid",  {31'b0, bus.mem_valid},  32'd0);
        chk("reset mem_we",     {31'b0, bus.mem_we},     32'd0);
        chk("reset mem_wdata",  bus.mem_wdata, 32'h0);
        rst = 1'b1;

        // SH into 0x22: a single merged write at the word address.
        w0 = wr_cnt;
        issue(1'b1, 3'b001, 32'h22, 32'h0000BEEF);
        chk("sh got", {31'b0, a_got}, 32'd1);
        chk("sh latency", a_lat, 32'd3);
        chk("sh write count", wr_cnt - w0, 32'd1);
        chk("sh write addr", wr_addr, 32'h20);
        chk("sh write data", wr_data, 32'hBEEF3344);
        @(negedge clk);
        chk("resp_valid one-cycle", {31'b0, bus.resp_valid}, 32'd0);

        vecs.push_back('{1'b0, 3'b000, 32'h12, 32'h0, 1'b0, 32'hFFFFFF99, 2});
        vecs.push_back('{1'b0, 3'b100, 32'h12, 32'h0, 1'b0, 32'h00000099, 2});
        vecs.push_back('{1'b0, 3'b001, 32'h12, 32'h0, 1'b0, 32'hFFFF8899, 2});
        vecs.push_back('{1'b0, 3'b101, 32'h10, 32'h0, 1'b0, 32'h0000AABB, 2});
        vecs.push_back('{1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h8899AABB, 2});
        vecs.push_back('{1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 32'hBEEF3344, 2});
        vecs.push_back('{1'b1, 3'b000, 32'h13, 32'h12345677, 1'b0, 32'h0, 3});
        vecs.push_back('{1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h7799AABB, 2});
        vecs.push_back('{1'b0, 3'b000, 32'h11, 32'h0, 1'b0, 32'hFFFFFFAA, 2});
        vecs.push_back('{1'b0, 3'b011, 32'h10, 32'h0, 1'b1, 32'h0, 2});
        vecs.push_back('{1'b1, 3'b100, 32'h10, 32'h0, 1'b1, 32'h0, 2});
        vecs.push_back('{1'b1, 3'b011, 32'h10, 32'h0, 1'b1, 32'h0, 2});
        vecs.push_back('{1'b0, 3'b110, 32'h10, 32'h0, 1'b1, 32'h0, 2});
        vecs.push_back('{1'b0, 3'b010, 32'h41, 32'h0, TRAP, 32'hCAFEF00D, 2});
        vecs.push_back('{1'b0, 3'b001, 32'h43, 32'h0, TRAP, 32'hFFFFCAFE, 2});
        vecs.push_back('{1'b0, 3'b101, 32'h41, 32'h0, TRAP, 32'h0000F00D, 2});

        foreach (vecs[i]) begin
            issue(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata);
            chk($sformatf("vec%0d got", i), {31'b0, a_got}, 32'd1);
            chk($sformatf("vec%0d latency", i), a_lat, vecs[i].lat);
            chk($sformatf("vec%0d fault", i), {31'b0, a_f}, {31'b0, vecs[i].fault});
            if (!vecs[i].fault) chk($sformatf("vec%0d rdata", i), a_rd, vecs[i].rdata);
        end

        // SW then LW issued in the SW's resp_valid cycle.
        issue(1'b1, 3'b010, 32'h30, 32'hDEADBEEF);
        chk("b2b sw latency", a_lat, 32'd2);
        chk("b2b resp_valid at reissue", {31'b0, bus.resp_valid}, 32'd1);
        issue(1'b0, 3'b010, 32'h30, 32'h0);
        chk("b2b lw latency", a_lat, 32'd2);
        chk("b2b lw rdata", a_rd, 32'hDEADBEEF);

        // Faults must not touch memory.
        mv_seen = 1'b0;
        issue(1'b0, 3'b010, 32'h41, 32'h0);
        chk("lw 0x41 fault", {31'b0, a_f}, {31'b0, TRAP});
        if (TRAP) chk("lw 0x41 no mem access", {31'b0, mv_seen}, 32'd0);
        else      chk("lw 0x41 rdata", a_rd, 32'hCAFEF00D);
        mv_seen = 1'b0;
        issue(1'b0, 3'b011, 32'h10, 32'h0);
        chk("funct3 011 fault", {31'b0, a_f}, 32'd1);
        chk("funct3 011 latency", a_lat, 32'd2);
        chk("funct3 011 no mem access", {31'b0, mv_seen}, 32'd0);

        // Reset during the WRITE cycle of an SB.
        w0 = wr_cnt;
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b000;
        bus.req_addr = 32'h50; bus.req_wdata = 32'h000000AA;
        @(posedge clk);
        @(negedge clk); bus.req_valid = 1'b0;
        @(negedge clk);
        chk("sb write strobe before reset", {31'b0, bus.mem_we}, 32'd1);
        rst = 1'b0;
        #1;
        chk("sb mem_we gated", {31'b0, bus.mem_we}, 32'd0);
        chk("sb mem_valid gated", {31'b0, bus.mem_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        chk("reset-drop idle", {31'b0, bus.req_ready}, 32'd1);
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            if (bus.resp_valid) seen++;
            @(negedge clk);
        end
        chk("reset-drop no resp", seen, 32'd0);
        chk("reset-drop no write", wr_cnt - w0, 32'd0);
        chk("reset-drop mem unchanged", mem[20], 32'h01020304);

        // Random requests against the reference model.
        for (int i = 0; i < 200; i++) begin
            we    = 1'($urandom_range(0, 1));
            f3    = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) begin
                if (we) f3 = 3'($urandom_range(0, 2));
                else begin
                    f3 = 3'($urandom_range(0, 4));
                    if (f3 == 3'd3) f3 = 3'd5;
                end
            end
            addr  = 32'($urandom_range(0, 255));
            wdata = $urandom;
            issue(we, f3, addr, wdata);
            chk($sformatf("rnd%0d got", i), {31'b0, a_got}, 32'd1);
            chk($sformatf("rnd%0d latency", i), a_lat, e_lat);
            chk($sformatf("rnd%0d fault", i), {31'b0, a_f}, {31'b0, e_f});
            if (!e_f) chk($sformatf("rnd%0d rdata", i), a_rd, e_rd);
        end
        @(negedge clk);

        bad = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== model_mem[i]) bad++;
        chk("final memory mismatching words", bad, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
